// File: rtl/user_r_stream_src.sv
// Producer-to-host read stream: circular FIFO with end-of-stream tracking and flush on close.
// Read data appears 1 cycle after an accepted rden; in_ready drops when full, closed, in reset or after eos.
module user_r_stream_src #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                       clkB,
  input  logic                       rst_clkB,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       eos_flag_clkB,
  input  logic                       user_r_mydevice_open,
  input  logic                       user_r_mydevice_rden,
  output logic                       user_r_mydevice_empty,
  output logic [DATA_W-1:0]          user_r_mydevice_data,
  output logic                       user_r_mydevice_eof,
  output logic [$clog2(DEPTH):0]     fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wrPtr, rdPtr;
  logic [CW-1:0]     count;
  logic              eosPending;
  logic              eofReg;
  logic [DATA_W-1:0] dataReg;
  logic              wrEn, rdEn, isEmpty;

  assign isEmpty  = (count == '0);
  assign in_ready = !rst_clkB && user_r_mydevice_open && (count < CW'(DEPTH)) && !eosPending;
  assign wrEn     = in_valid && in_ready;
  // A read needs a word present; at count==0 a concurrent write lands but is not readable yet.
  assign rdEn     = user_r_mydevice_open && user_r_mydevice_rden && !isEmpty && !eofReg;

  assign user_r_mydevice_empty = isEmpty;
  assign user_r_mydevice_data  = dataReg;
  assign user_r_mydevice_eof   = eofReg;
  assign fill_level            = count;

  always_ff @(posedge clkB) begin
    if (wrEn) mem[wrPtr] <= in_data;
  end

  always_ff @(posedge clkB) begin
    if (rst_clkB || !user_r_mydevice_open) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      eosPending <= 1'b0;
      eofReg     <= 1'b0;
      dataReg    <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + AW'(1);
      if (rdEn) begin
        rdPtr   <= rdPtr + AW'(1);
        dataReg <= mem[rdPtr];
      end
      case ({wrEn, rdEn})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (eos_flag_clkB) eosPending <= 1'b1;
      // eof follows the drain by one edge since it looks at the registered count.
      if (eosPending && isEmpty) eofReg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_user_r_stream_src.sv
// Directed bench for user_r_stream_src: ordering, full, wrap, eos, close/reopen, reset mid-stream.
module tb_user_r_stream_src;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic              clkB = 1'b0;
  logic              rst_clkB;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              eos_flag_clkB;
  logic              user_r_mydevice_open;
  logic              user_r_mydevice_rden;
  logic              user_r_mydevice_empty;
  logic [DATA_W-1:0] user_r_mydevice_data;
  logic              user_r_mydevice_eof;
  logic [4:0]        fill_level;

  int checks = 0;
  int errors = 0;

  always #5 clkB = ~clkB;

  user_r_stream_src #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clkB                  (clkB),
    .rst_clkB              (rst_clkB),
    .in_data               (in_data),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .eos_flag_clkB         (eos_flag_clkB),
    .user_r_mydevice_open  (user_r_mydevice_open),
    .user_r_mydevice_rden  (user_r_mydevice_rden),
    .user_r_mydevice_empty (user_r_mydevice_empty),
    .user_r_mydevice_data  (user_r_mydevice_data),
    .user_r_mydevice_eof   (user_r_mydevice_eof),
    .fill_level            (fill_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clkB);
    #1;
  endtask

  initial begin : stim
    logic [31:0] q[$];
    logic [31:0] expWord;
    int mc, sent, rcvd, cyc;
    logic iv, rd, wr, rdo;

    rst_clkB = 1'b1; in_data = '0; in_valid = 1'b0; eos_flag_clkB = 1'b0;
    user_r_mydevice_open = 1'b0; user_r_mydevice_rden = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_empty", user_r_mydevice_empty, 1);
    chk("rst_fill", fill_level, 0);
    chk("rst_eof", user_r_mydevice_eof, 0);
    chk("rst_data", user_r_mydevice_data, 0);

    rst_clkB = 1'b0; user_r_mydevice_open = 1'b1;
    tick();
    chk("open_in_ready", in_ready, 1);

    // Ordering
    in_valid = 1'b1;
    in_data = 32'h11; tick();
    in_data = 32'h22; tick();
    in_data = 32'h33; tick();
    in_valid = 1'b0;
    chk("ord_fill3", fill_level, 3);
    user_r_mydevice_rden = 1'b1;
    tick(); chk("ord_d0", user_r_mydevice_data, 32'h11);
    tick(); chk("ord_d1", user_r_mydevice_data, 32'h22);
    tick(); chk("ord_d2", user_r_mydevice_data, 32'h33);
    user_r_mydevice_rden = 1'b0;
    chk("ord_empty", user_r_mydevice_empty, 1);
    chk("ord_fill0", fill_level, 0);

    // Full, then read with a concurrent (refused) write
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = 32'h100 + i;
      tick();
    end
    chk("full_in_ready", in_ready, 0);
    chk("full_fill", fill_level, 16);
    in_data = 32'hDEAD;
    user_r_mydevice_rden = 1'b1;
    tick();
    in_valid = 1'b0; user_r_mydevice_rden = 1'b0;
    chk("full_rd_fill", fill_level, 15);
    chk("full_rd_data", user_r_mydevice_data, 32'h100);
    chk("full_rd_in_ready", in_ready, 1);
    user_r_mydevice_rden = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      tick();
      chk("full_drain", user_r_mydevice_data, 32'h100 + i);
    end
    user_r_mydevice_rden = 1'b0;
    chk("full_drain_empty", user_r_mydevice_empty, 1);

    // Wrap: random valid/rden against a queue model
    mc = 0; sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 40 && cyc < 2000) begin
      iv = (sent < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      rd = 1'($urandom_range(0, 1));
      in_valid = iv; in_data = 32'hA000_0000 + sent;
      user_r_mydevice_rden = rd;
      wr  = iv && (mc < DEPTH);
      rdo = rd && (mc > 0);
      #1;
      if (in_ready !== (mc < DEPTH)) chk("wrap_in_ready", in_ready, (mc < DEPTH));
      tick();
      cyc++;
      if (rdo) begin
        expWord = q.pop_front();
        mc--; rcvd++;
        chk("wrap_data", user_r_mydevice_data, expWord);
      end
      if (wr) begin
        q.push_back(32'hA000_0000 + sent);
        sent++; mc++;
      end
    end
    in_valid = 1'b0; user_r_mydevice_rden = 1'b0;
    chk("wrap_rcvd", rcvd, 40);
    chk("wrap_fill", fill_level, mc);

    // EOS
    in_valid = 1'b1;
    in_data = 32'hE1; tick();
    in_data = 32'hE2; tick();
    in_data = 32'hE3; in_valid = 1'b1; eos_flag_clkB = 1'b1; tick();
    eos_flag_clkB = 1'b0; in_data = 32'hE4;
    chk("eos_in_ready", in_ready, 0);
    chk("eos_edge_write", fill_level, 3);
    tick();
    in_valid = 1'b0;
    chk("eos_blocked", fill_level, 3);
    user_r_mydevice_rden = 1'b1;
    tick(); chk("eos_d0", user_r_mydevice_data, 32'hE1);
    tick(); chk("eos_d1", user_r_mydevice_data, 32'hE2);
    tick(); chk("eos_d2", user_r_mydevice_data, 32'hE3);
    chk("eos_empty", user_r_mydevice_empty, 1);
    chk("eos_eof_not_yet", user_r_mydevice_eof, 0);
    tick();
    chk("eos_eof", user_r_mydevice_eof, 1);
    chk("eos_hold", user_r_mydevice_data, 32'hE3);
    tick();
    chk("eos_eof_sticky", user_r_mydevice_eof, 1);
    user_r_mydevice_rden = 1'b0;

    // Close/reopen with 5 words queued and eos pending
    user_r_mydevice_open = 1'b0; tick();
    user_r_mydevice_open = 1'b1; tick();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 32'hC1 + i;
      tick();
    end
    in_valid = 1'b0; user_r_mydevice_rden = 1'b1; eos_flag_clkB = 1'b1;
    tick();
    user_r_mydevice_rden = 1'b0; eos_flag_clkB = 1'b0;
    chk("cls_pre_data", user_r_mydevice_data, 32'hC1);
    chk("cls_pre_fill", fill_level, 5);
    user_r_mydevice_open = 1'b0; user_r_mydevice_rden = 1'b1; in_valid = 1'b1;
    tick();
    user_r_mydevice_rden = 1'b0; in_valid = 1'b0;
    chk("cls_fill", fill_level, 0);
    chk("cls_eof", user_r_mydevice_eof, 0);
    chk("cls_data", user_r_mydevice_data, 0);
    chk("cls_in_ready", in_ready, 0);
    user_r_mydevice_open = 1'b1;
    #1;
    chk("reopen_in_ready", in_ready, 1);
    tick();

    // Reset mid-stream with 7 words queued and a concurrent rden
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'h70 + i;
      tick();
    end
    in_valid = 1'b0; user_r_mydevice_rden = 1'b1;
    tick();
    chk("rstm_pre_data", user_r_mydevice_data, 32'h70);
    chk("rstm_pre_fill", fill_level, 7);
    rst_clkB = 1'b1; in_valid = 1'b1; eos_flag_clkB = 1'b1;
    tick();
    in_valid = 1'b0; eos_flag_clkB = 1'b0;
    chk("rstm_empty", user_r_mydevice_empty, 1);
    chk("rstm_data", user_r_mydevice_data, 0);
    chk("rstm_eof", user_r_mydevice_eof, 0);
    chk("rstm_in_ready", in_ready, 0);
    rst_clkB = 1'b0;
    tick();
    chk("rstm_post_in_ready", in_ready, 1);
    tick();
    chk("rstm_no_stale", user_r_mydevice_data, 0);
    chk("rstm_still_empty", user_r_mydevice_empty, 1);
    chk("rstm_no_eof", user_r_mydevice_eof, 0);
    user_r_mydevice_rden = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/user_r_stream_src.md
USER_R_STREAM_SRC -- requirements
Module: user_r_stream_src

Interface
REQ-001 Parameter DATA_W, 32, width of stream words and FIFO entries.
REQ-002 Parameter DEPTH, 16, FIFO entry count; power of two, 4 to 256.
REQ-003 clkB  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_clkB  in  1  synchronous, active-high reset.
REQ-005 in_data  in  DATA_W  word from producer logic.
REQ-006 in_valid  in  1  producer offers in_data this cycle.
REQ-007 in_ready  out  1  block accepts in_data this cycle.
REQ-008 eos_flag_clkB  in  1  one-cycle end-of-stream pulse, already in the clkB domain.
REQ-009 user_r_mydevice_open  in  1  host has the read stream open.
REQ-010 user_r_mydevice_rden  in  1  host read strobe.
REQ-011 user_r_mydevice_empty  out  1  no word available to read.
REQ-012 user_r_mydevice_data  out  DATA_W  word returned for the previous accepted rden.
REQ-013 user_r_mydevice_eof  out  1  stream ended and drained.
REQ-014 fill_level  out  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 Storage SHALL be a circular FIFO of DEPTH entries with read and write pointers wrapping modulo DEPTH, and a count from 0 to DEPTH.
REQ-016 in_ready SHALL be computed combinationally from registered state: open=1, count<DEPTH and eos_pending=0.
REQ-017 A write SHALL occur on any edge with in_valid=1 and in_ready=1: in_data is stored at the write pointer, which then advances.
REQ-018 user_r_mydevice_empty SHALL equal (count==0), with no registered delay.
REQ-019 A read SHALL occur on any edge with rden=1, empty=0 and open=1: the head word is loaded into the data register and the read pointer advances.
REQ-020 user_r_mydevice_data SHALL therefore present the popped word in the cycle after the rden cycle (read latency 1), and SHALL hold its value when no read occurs.
REQ-021 rden while empty=1 SHALL be ignored: pointers, count and data are unchanged; this is not an error.
REQ-022 A simultaneous read and write on one edge SHALL leave count unchanged.
REQ-023 A simultaneous read and write at count==0 SHALL store the write word only; no read occurs.
REQ-024 At count==DEPTH, in_ready=0, so a simultaneous read alone SHALL bring count to DEPTH-1.
REQ-025 fill_level SHALL equal count.
REQ-026 eos_pending SHALL be set by eos_flag_clkB=1 while open=1.
REQ-027 eos_flag_clkB while eos_pending=1 or while open=0 SHALL be ignored.
REQ-028 While eos_pending=1, in_ready SHALL be 0. The eos pulse edge itself still accepts a write if in_ready was 1 in that cycle.
REQ-029 user_r_mydevice_eof SHALL be a register set on the first edge where eos_pending=1 and count==0, giving eof 1 cycle after the FIFO drains.
REQ-030 Once set, eof SHALL stay at 1 until open=0 or reset.
REQ-031 rden while eof=1 SHALL be ignored.
REQ-032 open sampled 0 SHALL, on that edge, flush the block:
- count, pointers, eos_pending and eof cleared to 0;
- data register cleared to 0;
- any concurrent read or write discarded.
REQ-033 Reopen (open 0->1) SHALL start an empty stream; in_ready rises in the first cycle with open=1.
REQ-034 Underflow (count<0) and overflow (count>DEPTH) SHALL be structurally impossible.

Reset
REQ-035 rst_clkB=1 SHALL, on the edge, clear:
- pointers, count, eos_pending, eof and data to 0;
- giving empty=1 and fill_level=0.
REQ-036 in_ready SHALL be 0 during reset and SHALL follow REQ-016 from the first cycle after rst_clkB falls.
REQ-037 Reset mid-operation SHALL discard FIFO contents and any pending eos, with no word emitted afterwards.
REQ-038 Reset SHALL take priority over open, rden, in_valid and eos_flag_clkB on the same edge.

Verification
REQ-039 Ordering: open=1, write 0x11,0x22,0x33, one rden per cycle -> data 0x11,0x22,0x33 on the three cycles after each rden; then empty=1, fill_level=0.
REQ-040 Full: write 16 words with no reads -> in_ready=0, fill_level=16. One rden plus in_valid in the same cycle -> read only, fill_level=15. Next cycle in_ready=1.
REQ-041 Wrap: stream 40 words with random rden and in_valid -> output sequence equals input sequence, with no loss or duplication.
REQ-042 EOS: 3 words queued, eos pulse -> in_ready=0 immediately. After 3 reads, eof=1 one cycle after empty=1. A further rden leaves data unchanged.
REQ-043 Close/reopen: 5 words queued and eof pending, open=0 one cycle -> fill_level=0, eof=0, data=0. Reopen -> in_ready=1.
REQ-044 Reset mid-stream: rst_clkB pulsed with 7 words queued and rden=1 in the same cycle -> empty=1, data=0, eof=0. No stale word appears afterwards.
